// File: rtl/imm_pkg.sv
// Shared constants for the immediate generator: format select codes and RV32/RV64 major opcodes.
package imm_pkg;

    localparam int IMM_OP_W = 4;

    typedef logic [IMM_OP_W-1:0] imm_op_t;

    localparam imm_op_t IMM_NONE    = 4'd0;
    localparam imm_op_t IMM_I       = 4'd1;
    localparam imm_op_t IMM_S       = 4'd2;
    localparam imm_op_t IMM_B       = 4'd3;
    localparam imm_op_t IMM_U       = 4'd4;
    localparam imm_op_t IMM_J       = 4'd5;
    localparam imm_op_t IMM_Z       = 4'd6;
    localparam imm_op_t IMM_SH      = 4'd7;
    localparam imm_op_t IMM_ILLEGAL = 4'd15;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: (inst, format) -> (XLEN immediate, applied format, error).
// IMM_AUTO_DECODE_EN derives the format from the opcode/funct3 instead of the op input.
module imm_extract import imm_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  imm_op_t         op,
    output logic [XLEN-1:0] imm,
    output imm_op_t         op_eff,
    output logic            err
);

`ifdef IMM_AUTO_DECODE_EN
    // Format derived from the major opcode; anything unrecognised maps to the illegal code.
    always_comb begin
        op_eff = IMM_ILLEGAL;
        case (inst[6:0])
            OPC_LOAD, OPC_JALR: op_eff = IMM_I;
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                // funct3 001/101 are the shift-immediate encodings
                if (inst[13:12] == 2'b01) begin
                    op_eff = IMM_SH;
                end else begin
                    op_eff = IMM_I;
                end
            end
            OPC_STORE:            op_eff = IMM_S;
            OPC_BRANCH:           op_eff = IMM_B;
            OPC_LUI, OPC_AUIPC:   op_eff = IMM_U;
            OPC_JAL:              op_eff = IMM_J;
            OPC_SYSTEM: begin
                if (inst[14]) begin
                    op_eff = IMM_Z;
                end else begin
                    op_eff = IMM_I;
                end
            end
            OPC_OP, OPC_OP_32:    op_eff = IMM_NONE;
            default:              op_eff = IMM_ILLEGAL;
        endcase
    end
`else
    // Format taken directly from the select input.
    always_comb begin
        op_eff = op;
    end
`endif

    // Field gather and extension; signed casts sign-extend, unsigned casts zero-extend.
    always_comb begin
        imm = {XLEN{1'b0}};
        err = 1'b0;
        case (op_eff)
            IMM_NONE: imm = {XLEN{1'b0}};
            IMM_I:    imm = XLEN'($signed(inst[31:20]));
            IMM_S:    imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            IMM_B:    imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            IMM_U:    imm = XLEN'($signed({inst[31:12], 12'h000}));
            IMM_J:    imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            IMM_Z:    imm = XLEN'(inst[19:15]);
            IMM_SH: begin
                if (XLEN == 64) begin
                    imm = XLEN'(inst[25:20]);
                end else begin
                    imm = XLEN'(inst[24:20]);
                end
            end
            default: begin
                imm = {XLEN{1'b0}};
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator with valid/ready flow control and flush.
// Optional build macro IMM_AUTO_DECODE_EN (handled in imm_extract) selects opcode-based format decode.
module imm_gen_pipe import imm_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  imm_op_t         in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output imm_op_t         out_op,
    output logic            out_err
);

    logic [XLEN-1:0] ext_imm_s;
    imm_op_t         ext_op_s;
    logic            ext_err_s;
    logic            s1_adv_s;
    logic            s2_adv_s;
    logic            accept_s;

    logic            s1_v_q,   s1_v_d;
    logic [XLEN-1:0] s1_imm_q, s1_imm_d;
    logic [XLEN-1:0] s1_pc_q,  s1_pc_d;
    imm_op_t         s1_op_q,  s1_op_d;
    logic            s1_err_q, s1_err_d;

    logic            s2_v_q,   s2_v_d;
    logic [XLEN-1:0] s2_imm_q, s2_imm_d;
    logic [XLEN-1:0] s2_tgt_q, s2_tgt_d;
    imm_op_t         s2_op_q,  s2_op_d;
    logic            s2_err_q, s2_err_d;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .inst   (in_inst),
        .op     (in_op),
        .imm    (ext_imm_s),
        .op_eff (ext_op_s),
        .err    (ext_err_s)
    );

    // Stage advance; in_ready deliberately has no path from in_valid.
    always_comb begin
        s2_adv_s = !s2_v_q || out_ready;
        s1_adv_s = !s1_v_q || s2_adv_s;
        in_ready = s1_adv_s && !flush;
        accept_s = in_valid && in_ready;
    end

    // Stage 1 next state: capture extracted fields on accept.
    always_comb begin
        if (flush) begin
            s1_v_d = 1'b0;
        end else if (s1_adv_s) begin
            s1_v_d = accept_s;
        end else begin
            s1_v_d = s1_v_q;
        end
        if (accept_s) begin
            s1_imm_d = ext_imm_s;
            s1_pc_d  = in_pc;
            s1_op_d  = ext_op_s;
            s1_err_d = ext_err_s;
        end else begin
            s1_imm_d = s1_imm_q;
            s1_pc_d  = s1_pc_q;
            s1_op_d  = s1_op_q;
            s1_err_d = s1_err_q;
        end
    end

    // Stage 2 next state: payload frozen while the output is stalled; target wraps modulo 2^XLEN.
    always_comb begin
        if (flush) begin
            s2_v_d = 1'b0;
        end else if (s2_adv_s) begin
            s2_v_d = s1_v_q;
        end else begin
            s2_v_d = s2_v_q;
        end
        if (s2_adv_s && s1_v_q) begin
            s2_imm_d = s1_imm_q;
            s2_tgt_d = s1_pc_q + s1_imm_q;
            s2_op_d  = s1_op_q;
            s2_err_d = s1_err_q;
        end else begin
            s2_imm_d = s2_imm_q;
            s2_tgt_d = s2_tgt_q;
            s2_op_d  = s2_op_q;
            s2_err_d = s2_err_q;
        end
    end

    // Pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s1_imm_q <= {XLEN{1'b0}};
            s1_pc_q  <= {XLEN{1'b0}};
            s1_op_q  <= IMM_NONE;
            s1_err_q <= 1'b0;
            s2_v_q   <= 1'b0;
            s2_imm_q <= {XLEN{1'b0}};
            s2_tgt_q <= {XLEN{1'b0}};
            s2_op_q  <= IMM_NONE;
            s2_err_q <= 1'b0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_imm_q <= s1_imm_d;
            s1_pc_q  <= s1_pc_d;
            s1_op_q  <= s1_op_d;
            s1_err_q <= s1_err_d;
            s2_v_q   <= s2_v_d;
            s2_imm_q <= s2_imm_d;
            s2_tgt_q <= s2_tgt_d;
            s2_op_q  <= s2_op_d;
            s2_err_q <= s2_err_d;
        end
    end

    assign out_valid  = s2_v_q;
    assign out_imm    = s2_imm_q;
    assign out_target = s2_tgt_q;
    assign out_op     = s2_op_q;
    assign out_err    = s2_err_q;

endmodule
